// File: rtl/retire_buffer.sv
// retire_buffer: in-order retire buffer; allocates IDs at issue, takes out-of-order
// writebacks and releases entries in order as commit acknowledges them.
package riscv;
   localparam int unsigned XLEN = 32;
   localparam int unsigned TRANS_ID_BITS = 3;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic [XLEN-1:0]          pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [4:0]               rd;
      logic [XLEN-1:0]          result;
      logic                     valid;
      exception_t               ex;
   } scoreboard_entry_t;
endpackage

module retire_buffer #(
   parameter int unsigned NR_ENTRIES      = 8,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned NR_WB_PORTS     = 4,
   localparam int unsigned TRANS_ID_BITS  = $clog2(NR_ENTRIES)
) (
   input  logic                                         clk_i,
   input  logic                                         rst_i,
   input  logic                                         flush_i,
   input  logic                                         issue_valid_i,
   input  riscv::scoreboard_entry_t                     issue_instr_i,
   output logic                                         issue_ready_o,
   output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
   input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
   input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
   input  logic [NR_WB_PORTS-1:0][riscv::XLEN-1:0]      wb_data_i,
   input  riscv::exception_t [NR_WB_PORTS-1:0]          wb_ex_i,
   output riscv::scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_o,
   input  logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i,
   output logic                                         empty_o
);
   typedef logic [TRANS_ID_BITS-1:0] ptr_t;
   typedef logic [TRANS_ID_BITS:0]   cnt_t;

   riscv::scoreboard_entry_t mem [NR_ENTRIES];
   logic [NR_ENTRIES-1:0] occ, done;
   ptr_t head, tail;
   cnt_t count, pop;
   logic fire, clr;

   assign issue_ready_o    = count < cnt_t'(NR_ENTRIES);
   assign issue_trans_id_o = tail;
   assign empty_o          = count == '0;
   assign fire             = issue_valid_i && issue_ready_o;
   assign clr              = rst_i || flush_i;

   // an ack only counts while every older ack is set and its entry is occupied
   always_comb begin
      logic run;
      pop = '0;
      run = 1'b1;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         run = run & commit_ack_i[i] & occ[ptr_t'(head + ptr_t'(i))];
         pop = pop + cnt_t'(run);
      end
   end

   always_comb begin
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         commit_instr_o[i]       = mem[ptr_t'(head + ptr_t'(i))];
         commit_instr_o[i].valid = occ[ptr_t'(head + ptr_t'(i))] & done[ptr_t'(head + ptr_t'(i))];
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         occ   <= '0;
         done  <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int p = NR_WB_PORTS - 1; p >= 0; p--)
            if (wb_valid_i[p] && occ[wb_trans_id_i[p]]) done[wb_trans_id_i[p]] <= 1'b1;
         for (int i = 0; i < NR_COMMIT_PORTS; i++)
            if (cnt_t'(i) < pop) begin
               occ[ptr_t'(head + ptr_t'(i))]  <= 1'b0;
               done[ptr_t'(head + ptr_t'(i))] <= 1'b0;
            end
         if (fire) begin
            occ[tail]  <= 1'b1;
            done[tail] <= issue_instr_i.ex.valid;
            tail       <= tail + ptr_t'(1);
         end
         head  <= head + ptr_t'(pop);
         count <= count + cnt_t'(fire) - pop;
      end
   end

   // payload storage needs no reset; descending port order lets the lowest port win
   always_ff @(posedge clk_i) begin
      if (!clr) begin
         for (int p = NR_WB_PORTS - 1; p >= 0; p--)
            if (wb_valid_i[p] && occ[wb_trans_id_i[p]]) begin
               mem[wb_trans_id_i[p]].result <= wb_data_i[p];
               if (wb_ex_i[p].valid) mem[wb_trans_id_i[p]].ex <= wb_ex_i[p];
            end
         if (fire) begin
            mem[tail]          <= issue_instr_i;
            mem[tail].trans_id <= (riscv::TRANS_ID_BITS)'(tail);
         end
      end
   end
endmodule
